pixel_write_arbiter: RTL and testbench
======================================

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 512, pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 384, rows per frame.
REQ-003 SHALL have parameter COLOR_WIDTH, default 16, padded pixel width.
REQ-004 SHALL have parameter ADDR_BITS, default 18, pixel BRAM port-A address width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports ray_valid input 1 and ray_ready output 1, the ray-write handshake.
REQ-008 SHALL have ports ray_x input 16 and ray_y input 16, the ray pixel coordinates.
REQ-009 SHALL have port ray_pixel  input  COLOR_WIDTH  the ray pixel value.
REQ-010 SHALL have ports clear_start input 1 (one-cycle request) and clear_color input COLOR_WIDTH (fill value).
REQ-011 SHALL have ports clear_busy output 1 and clear_done output 1 (one-cycle pulse).
REQ-012 SHALL have ports bram_we output 1, bram_addr output ADDR_BITS and bram_din output COLOR_WIDTH, all driving pixel BRAM port A.
REQ-013 SHALL have ports write_count output 32 (ray writes issued) and drop_count output 16 (out-of-range ray writes discarded).

Function
REQ-014 SHALL buffer accepted ray writes in a 4-entry FIFO holding {address, pixel}, where address = FRAME_WIDTH*ray_y + ray_x truncated to ADDR_BITS.
REQ-015 SHALL assert ray_ready exactly when the FIFO holds fewer than 4 entries; a write is accepted on a cycle with ray_valid && ray_ready.
REQ-016 SHALL discard an accepted write with ray_x >= FRAME_WIDTH or ray_y >= FRAME_HEIGHT without pushing it, and SHALL increment drop_count, saturating at 0xFFFF.
REQ-017 SHALL run a two-state FSM, IDLE and CLEAR.
REQ-018 SHALL go IDLE -> CLEAR on clear_start in IDLE, latching clear_color and zeroing the clear address counter; clear_start in CLEAR SHALL be ignored.
REQ-019 SHALL, in CLEAR, issue one write per cycle at addresses 0..FRAME_WIDTH*FRAME_HEIGHT-1 in order with the latched color, then return to IDLE.
REQ-020 SHALL pulse clear_done the cycle after the final clear write appears on bram_we, and SHALL hold clear_busy high for every cycle in CLEAR.
REQ-021 SHALL never pop the FIFO in CLEAR, giving clear strict priority; ray writes SHALL keep being accepted until the FIFO is full.
REQ-022 SHALL, in IDLE with the FIFO non-empty, pop one entry per cycle.
REQ-023 SHALL register bram_we, bram_addr and bram_din, giving a one-cycle latency from pop or clear step to the port-A write.
REQ-024 SHALL, when a write is accepted with the FIFO empty in IDLE, show it on bram_we exactly two cycles after acceptance (push, pop, register).
REQ-025 SHALL allow a simultaneous push and pop, leaving the FIFO occupancy unchanged.
REQ-026 SHALL hold bram_we low on cycles with no pop and no clear step; bram_addr and bram_din SHALL then hold their last values.
REQ-027 SHALL increment write_count, wrapping modulo 2^32, on each ray write issued to port A.

Reset
REQ-028 SHALL, while rst is high, immediately force FSM = IDLE, FIFO empty, ray_ready = 1, and bram_we, bram_addr, bram_din, clear_busy, clear_done, write_count and drop_count all 0.
REQ-029 SHALL, on reset mid-clear, abort the clear with no clear_done pulse and discard all buffered ray writes.

Configuration
REQ-030 SHALL, with macro PIXEL_ARB_CLEAR_EN defined, include the CLEAR engine as specified above.
REQ-031 SHALL, without PIXEL_ARB_CLEAR_EN, omit the CLEAR engine: clear_start and clear_color ignored, clear_busy and clear_done tied 0, FSM permanently IDLE.

Verification
REQ-032 SHALL cover a single write: after reset, x=3, y=2, pixel=0x0ABC accepted at cycle N -> bram_we=1, bram_addr=1027, bram_din=0x0ABC at N+2; write_count=1.
REQ-033 SHALL cover an out-of-range write: x=512, y=0 -> no bram_we; drop_count=1; write_count=0.
REQ-034 SHALL cover a full clear: clear_start with clear_color=0x0F00 -> 196608 consecutive writes, addr 0..196607, din 0x0F00; clear_done one cycle after addr 196607; clear_busy low afterward.
REQ-035 SHALL cover backpressure: 6 ray writes offered during a clear -> ray_ready low after 4 accepted; after clear_done the 4 drain on consecutive cycles, then the remaining 2 are accepted and written.
REQ-036 SHALL cover reset mid-clear: rst at clear address 1000 -> all outputs 0 at once, no clear_done; a new clear_start restarts from address 0.
REQ-037 SHALL cover the build without PIXEL_ARB_CLEAR_EN: clear_start pulsed -> clear_busy stays 0 and ray writes still reach port A with two-cycle latency.

Source files
------------

// File: rtl/pixel_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_arbiter_if
// Description : Ray-write handshake, clear control and pixel BRAM port-A bus
//               shared between the pixel write arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_write_arbiter_if #(
  parameter int COLOR_WIDTH = 16,
  parameter int ADDR_BITS   = 18
);
  logic                   ray_valid;
  logic                   ray_ready;
  logic [15:0]            ray_x;
  logic [15:0]            ray_y;
  logic [COLOR_WIDTH-1:0] ray_pixel;
  logic                   clear_start;
  logic [COLOR_WIDTH-1:0] clear_color;
  logic                   clear_busy;
  logic                   clear_done;
  logic                   bram_we;
  logic [ADDR_BITS-1:0]   bram_addr;
  logic [COLOR_WIDTH-1:0] bram_din;
  logic [31:0]            write_count;
  logic [15:0]            drop_count;

  // Producer side: ray source, clear requester and BRAM/status consumer
  modport master (
    output ray_valid, ray_x, ray_y, ray_pixel, clear_start, clear_color,
    input  ray_ready, clear_busy, clear_done, bram_we, bram_addr, bram_din,
           write_count, drop_count
  );

  // Arbiter side
  modport slave (
    input  ray_valid, ray_x, ray_y, ray_pixel, clear_start, clear_color,
    output ray_ready, clear_busy, clear_done, bram_we, bram_addr, bram_din,
           write_count, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_write_arbiter
// Description : Buffers ray pixel writes in a 4-entry FIFO and arbitrates them
//               onto pixel BRAM port A against an optional frame-clear engine
//               that has strict priority. The clear engine is built only when
//               the macro PIXEL_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_write_arbiter #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int COLOR_WIDTH  = 16,
  parameter int ADDR_BITS    = 18
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pixel_write_arbiter_if.slave   bus
);

  localparam int          c_ENTRY_W = ADDR_BITS + COLOR_WIDTH;
  localparam logic [31:0] c_FW      = FRAME_WIDTH;
  localparam logic [31:0] c_FH      = FRAME_HEIGHT;

  // FIFO storage and bookkeeping
  logic [c_ENTRY_W-1:0]   r_fifo [0:3];
  logic [1:0]             r_wr_ptr;
  logic [1:0]             r_rd_ptr;
  logic [2:0]             r_count;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_in_range;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [c_ENTRY_W-1:0]   w_head;

  // Clear-engine view used by the port-A mux
  logic                   w_in_clear;
  logic [ADDR_BITS-1:0]   w_clr_addr;
  logic [COLOR_WIDTH-1:0] w_clr_color;
  logic                   w_clear_done;

  // Registered port-A and statistics
  logic                   r_bram_we;
  logic [ADDR_BITS-1:0]   r_bram_addr;
  logic [COLOR_WIDTH-1:0] r_bram_din;
  logic [31:0]            r_write_count;
  logic [15:0]            r_drop_count;

  assign w_ready    = (r_count != 3'd4);
  assign w_accept   = bus.ray_valid && w_ready;
  assign w_in_range = ({16'd0, bus.ray_x} < c_FW) && ({16'd0, bus.ray_y} < c_FH);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_addr     = ADDR_BITS'(c_FW * {16'd0, bus.ray_y} + {16'd0, bus.ray_x});
  // Clear owns port A outright; the FIFO only drains while idle
  assign w_pop      = !w_in_clear && (r_count != 3'd0);
  assign w_head     = r_fifo[r_rd_ptr];

`ifdef PIXEL_ARB_CLEAR_EN
  localparam logic [0:0]           S_IDLE      = 1'b0;
  localparam logic [0:0]           S_CLEAR     = 1'b1;
  localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [ADDR_BITS-1:0]   r_clr_addr;
  logic [COLOR_WIDTH-1:0] r_clr_color;
  logic                   r_last_q;
  logic                   r_clear_done;
  logic                   w_last_step;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state: start on request in IDLE, leave after the final address
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.clear_start) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_addr == c_LAST_ADDR) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_clear  = (r_state == S_CLEAR);
    w_last_step = (r_state == S_CLEAR) && (r_clr_addr == c_LAST_ADDR);
  end

  // Clear address/color and the done pulse, one cycle behind the last BRAM write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr   <= '0;
      r_clr_color  <= '0;
      r_last_q     <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.clear_start) begin
        r_clr_addr  <= '0;
        r_clr_color <= bus.clear_color;
      end else if (r_state == S_CLEAR) begin
        r_clr_addr  <= r_clr_addr + 1'b1;
      end
      r_last_q     <= w_last_step;
      r_clear_done <= r_last_q;
    end
  end

  assign w_clr_addr   = r_clr_addr;
  assign w_clr_color  = r_clr_color;
  assign w_clear_done = r_clear_done;
`else
  logic w_unused_clear;

  assign w_in_clear     = 1'b0;
  assign w_clr_addr     = '0;
  assign w_clr_color    = '0;
  assign w_clear_done   = 1'b0;
  assign w_unused_clear = ^{bus.clear_start, bus.clear_color};
`endif

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage; contents are meaningless while the count is zero
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_addr, bus.ray_pixel};
  end

  // Port-A register stage: clear step first, else FIFO pop, else hold addr/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bram_we     <= 1'b0;
      r_bram_addr   <= '0;
      r_bram_din    <= '0;
      r_write_count <= '0;
    end else if (w_in_clear) begin
      r_bram_we   <= 1'b1;
      r_bram_addr <= w_clr_addr;
      r_bram_din  <= w_clr_color;
    end else if (w_pop) begin
      r_bram_we     <= 1'b1;
      r_bram_addr   <= w_head[c_ENTRY_W-1:COLOR_WIDTH];
      r_bram_din    <= w_head[COLOR_WIDTH-1:0];
      r_write_count <= r_write_count + 32'd1;
    end else begin
      r_bram_we <= 1'b0;
    end
  end

  // Saturating count of out-of-frame writes that were accepted and discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_drop_count <= '0;
    else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end

  assign bus.ray_ready   = w_ready;
  assign bus.clear_busy  = w_in_clear;
  assign bus.clear_done  = w_clear_done;
  assign bus.bram_we     = r_bram_we;
  assign bus.bram_addr   = r_bram_addr;
  assign bus.bram_din    = r_bram_din;
  assign bus.write_count = r_write_count;
  assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_write_arbiter
// Description : Directed self-checking bench for pixel_write_arbiter. Clear
//               scenarios are compiled in with PIXEL_ARB_CLEAR_EN; that build
//               uses a 4-row frame so a full sweep stays short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_write_arbiter;
  localparam int FW = 512;
`ifdef PIXEL_ARB_CLEAR_EN
  localparam int FH = 4;
`else
  localparam int FH = 384;
`endif
  localparam int CW   = 16;
  localparam int AB   = 18;
  localparam int NPIX = FW * FH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter_if #(.COLOR_WIDTH(CW), .ADDR_BITS(AB)) bus ();

  pixel_write_arbiter #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .COLOR_WIDTH(CW), .ADDR_BITS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic idle_inputs();
    bus.ray_valid = 1'b0; bus.ray_x = '0; bus.ray_y = '0; bus.ray_pixel = '0;
    bus.clear_start = 1'b0; bus.clear_color = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b0)      begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd0)   begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'd0)    begin n_fail++; $display("FAIL reset_din: got %h want 0", bus.bram_din); end
    n_checks++; if (bus.write_count !== 32'd0) begin n_fail++; $display("FAIL reset_wcount: got %0d want 0", bus.write_count); end
    n_checks++; if (bus.drop_count !== 16'd0)  begin n_fail++; $display("FAIL reset_dcount: got %0d want 0", bus.drop_count); end
    n_checks++; if (bus.ray_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ray_ready); end
    n_checks++; if (bus.clear_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.clear_busy); end
    n_checks++; if (bus.clear_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.clear_done); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.ray_valid = 1'b1; bus.ray_x = 16'd3; bus.ray_y = 16'd2; bus.ray_pixel = 16'h0ABC;
    @(negedge clk); bus.ray_valid = 1'b0;
    n_checks++; if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL single_we_n1: got %b want 0", bus.bram_we); end
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b1)      begin n_fail++; $display("FAIL single_we_n2: got %b want 1", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd1027) begin n_fail++; $display("FAIL single_addr: got %0d want 1027", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'h0ABC) begin n_fail++; $display("FAIL single_din: got %h want 0abc", bus.bram_din); end
    n_checks++; if (bus.write_count !== 32'd1) begin n_fail++; $display("FAIL single_wcount: got %0d want 1", bus.write_count); end
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b0)       begin n_fail++; $display("FAIL single_we_n3: got %b want 0", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd1027) begin n_fail++; $display("FAIL single_hold_addr: got %0d want 1027", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'h0ABC)  begin n_fail++; $display("FAIL single_hold_din: got %h want 0abc", bus.bram_din); end
  endtask

  task automatic test_out_of_range();
    logic saw_we;
    logic [17:0] exp_addr;
    apply_reset();
    bus.ray_valid = 1'b1; bus.ray_x = 16'd512; bus.ray_y = 16'd0; bus.ray_pixel = 16'h1111;
    @(negedge clk);
    bus.ray_x = 16'd0; bus.ray_y = 16'(FH);
    @(negedge clk); bus.ray_valid = 1'b0;
    saw_we = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.bram_we !== 1'b0) saw_we = 1'b1; end
    n_checks++; if (saw_we !== 1'b0)          begin n_fail++; $display("FAIL oor_no_we: got %b want 0", saw_we); end
    n_checks++; if (bus.drop_count !== 16'd2) begin n_fail++; $display("FAIL oor_dcount: got %0d want 2", bus.drop_count); end
    n_checks++; if (bus.write_count !== 32'd0) begin n_fail++; $display("FAIL oor_wcount: got %0d want 0", bus.write_count); end
    // Bottom-right corner pixel is the last in-range address
    exp_addr = 18'(FW * (FH - 1) + FW - 1);
    bus.ray_valid = 1'b1; bus.ray_x = 16'(FW - 1); bus.ray_y = 16'(FH - 1); bus.ray_pixel = 16'h7E57;
    @(negedge clk); bus.ray_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b1)       begin n_fail++; $display("FAIL corner_we: got %b want 1", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== exp_addr) begin n_fail++; $display("FAIL corner_addr: got %0d want %0d", bus.bram_addr, exp_addr); end
    n_checks++; if (bus.drop_count !== 16'd2)   begin n_fail++; $display("FAIL corner_dcount: got %0d want 2", bus.drop_count); end
    n_checks++; if (bus.write_count !== 32'd1)  begin n_fail++; $display("FAIL corner_wcount: got %0d want 1", bus.write_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vx [5] = '{16'd0, 16'd5, 16'd600, 16'd10, 16'd1};
    logic [15:0] vy [5] = '{16'd0, 16'd7, 16'd1, 16'd3, 16'd1};
    logic [15:0] vp [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic        ew [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] ea [5] = '{18'd0, 18'd3589, 18'd0, 18'd1546, 18'd513};
    logic [31:0] wc0;
    logic [15:0] dc0;
    @(negedge clk);
    wc0 = bus.write_count; dc0 = bus.drop_count;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2) begin
        n_checks++; if (bus.bram_we !== ew[i-2]) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b want %b", i-2, bus.bram_we, ew[i-2]); end
        if (ew[i-2]) begin
          n_checks++; if (bus.bram_addr !== ea[i-2]) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i-2, bus.bram_addr, ea[i-2]); end
          n_checks++; if (bus.bram_din !== vp[i-2])  begin n_fail++; $display("FAIL b2b_din[%0d]: got %h want %h", i-2, bus.bram_din, vp[i-2]); end
        end
      end
      n_checks++; if (bus.ray_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.ray_ready); end
      if (i < 5) begin
        bus.ray_valid = 1'b1; bus.ray_x = vx[i]; bus.ray_y = vy[i]; bus.ray_pixel = vp[i];
      end else begin
        bus.ray_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++; if (bus.write_count !== wc0 + 32'd4) begin n_fail++; $display("FAIL b2b_wcount: got %0d want %0d", bus.write_count, wc0 + 32'd4); end
    n_checks++; if (bus.drop_count !== dc0 + 16'd1)  begin n_fail++; $display("FAIL b2b_dcount: got %0d want %0d", bus.drop_count, dc0 + 16'd1); end
  endtask

  task automatic test_reset_async();
    @(negedge clk);
    bus.ray_valid = 1'b1; bus.ray_x = 16'd4; bus.ray_y = 16'd0; bus.ray_pixel = 16'hAAAA;
    @(negedge clk);
    bus.ray_x = 16'd5; bus.ray_pixel = 16'hBBBB;
    @(negedge clk); bus.ray_valid = 1'b0;
    n_checks++; if (bus.bram_addr !== 18'd4) begin n_fail++; $display("FAIL rstasync_pre_addr: got %0d want 4", bus.bram_addr); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.bram_we !== 1'b0)       begin n_fail++; $display("FAIL rstasync_we: got %b want 0", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd0)    begin n_fail++; $display("FAIL rstasync_addr: got %0d want 0", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'd0)     begin n_fail++; $display("FAIL rstasync_din: got %h want 0", bus.bram_din); end
    n_checks++; if (bus.write_count !== 32'd0)  begin n_fail++; $display("FAIL rstasync_wcount: got %0d want 0", bus.write_count); end
    n_checks++; if (bus.drop_count !== 16'd0)   begin n_fail++; $display("FAIL rstasync_dcount: got %0d want 0", bus.drop_count); end
    n_checks++; if (bus.ray_ready !== 1'b1)     begin n_fail++; $display("FAIL rstasync_ready: got %b want 1", bus.ray_ready); end
    @(negedge clk); rst = 1'b0;
    begin
      logic saw_we = 1'b0;
      repeat (3) begin @(negedge clk); if (bus.bram_we !== 1'b0) saw_we = 1'b1; end
      n_checks++; if (saw_we !== 1'b0) begin n_fail++; $display("FAIL rstasync_fifo_flushed: got %b want 0", saw_we); end
    end
  endtask

`ifndef PIXEL_ARB_CLEAR_EN
  task automatic test_clear_ignored();
    @(negedge clk);
    bus.clear_start = 1'b1; bus.clear_color = 16'h0F00;
    bus.ray_valid = 1'b1; bus.ray_x = 16'd3; bus.ray_y = 16'd2; bus.ray_pixel = 16'h1234;
    @(negedge clk);
    bus.clear_start = 1'b0; bus.ray_valid = 1'b0;
    n_checks++; if (bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL noclr_busy1: got %b want 0", bus.clear_busy); end
    n_checks++; if (bus.bram_we !== 1'b0)    begin n_fail++; $display("FAIL noclr_we1: got %b want 0", bus.bram_we); end
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b1)       begin n_fail++; $display("FAIL noclr_we2: got %b want 1", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd1027) begin n_fail++; $display("FAIL noclr_addr: got %0d want 1027", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'h1234)  begin n_fail++; $display("FAIL noclr_din: got %h want 1234", bus.bram_din); end
    n_checks++; if (bus.clear_busy !== 1'b0)    begin n_fail++; $display("FAIL noclr_busy2: got %b want 0", bus.clear_busy); end
    n_checks++; if (bus.clear_done !== 1'b0)    begin n_fail++; $display("FAIL noclr_done: got %b want 0", bus.clear_done); end
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL noclr_we3: got %b want 0", bus.bram_we); end
  endtask
`else
  task automatic test_full_clear();
    int bad = 0;
    @(negedge clk);
    bus.clear_start = 1'b1; bus.clear_color = 16'h0F00;
    @(negedge clk);
    bus.clear_start = 1'b0; bus.clear_color = 16'h1234;
    n_checks++; if (bus.clear_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b want 1", bus.clear_busy); end
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clk);
      if (bus.bram_we !== 1'b1 || bus.bram_addr !== 18'(k) || bus.bram_din !== 16'h0F00) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_sweep: got %0d bad writes want 0", bad); end
    @(negedge clk);
    n_checks++; if (bus.clear_done !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %b want 1", bus.clear_done); end
    n_checks++; if (bus.bram_we !== 1'b0)    begin n_fail++; $display("FAIL clr_we_after: got %b want 0", bus.bram_we); end
    @(negedge clk);
    n_checks++; if (bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_pulse: got %b want 0", bus.clear_done); end
    n_checks++; if (bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy_after: got %b want 0", bus.clear_busy); end
  endtask

  task automatic test_clear_backpressure();
    int          acc = 0, nrw = 0, nd = 0, bad = 0;
    int          rw_cyc [6];
    logic [17:0] rw_addr [6];
    logic [15:0] rw_din [6];
    logic        prev_v = 1'b0, prev_r = 1'b0, seen_low = 1'b0, checked = 1'b0;
    @(negedge clk);
    bus.clear_start = 1'b1; bus.clear_color = 16'h0F00;
    for (int cyc = 0; cyc < 3 * NPIX && nrw < 6; cyc++) begin
      @(negedge clk);
      bus.clear_start = 1'b0;
      if (prev_v && prev_r) acc++;
      if (bus.bram_we === 1'b1 && bus.bram_din !== 16'h0F00 && nrw < 6) begin
        rw_cyc[nrw] = cyc; rw_addr[nrw] = bus.bram_addr; rw_din[nrw] = bus.bram_din; nrw++;
      end
      if (bus.clear_done === 1'b1) nd++;
      if (acc == 4 && !checked && bus.clear_busy === 1'b1) begin
        seen_low = (bus.ray_ready === 1'b0); checked = 1'b1;
      end
      if (cyc >= 1 && acc < 6) begin
        bus.ray_valid = 1'b1; bus.ray_x = 16'(acc); bus.ray_y = 16'd1; bus.ray_pixel = 16'hA000 + 16'(acc);
      end else begin
        bus.ray_valid = 1'b0;
      end
      prev_v = bus.ray_valid; prev_r = bus.ray_ready;
    end
    bus.ray_valid = 1'b0;
    n_checks++; if (seen_low !== 1'b1) begin n_fail++; $display("FAIL bp_ready_low: got %b want 1", seen_low); end
    n_checks++; if (nrw !== 6)         begin n_fail++; $display("FAIL bp_ray_writes: got %0d want 6", nrw); end
    n_checks++; if (nd !== 1)          begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", nd); end
    for (int j = 0; j < nrw; j++)
      if (rw_addr[j] !== 18'(512 + j) || rw_din[j] !== 16'hA000 + 16'(j)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_order: got %0d bad want 0", bad); end
    if (nrw == 6) begin
      n_checks++; if (rw_cyc[3] - rw_cyc[0] !== 3) begin n_fail++; $display("FAIL bp_drain_span: got %0d want 3", rw_cyc[3] - rw_cyc[0]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    logic found = 1'b0, saw = 1'b0, done = 1'b0;
    @(negedge clk);
    bus.clear_start = 1'b1; bus.clear_color = 16'h00F0;
    @(negedge clk); bus.clear_start = 1'b0;
    for (int c = 0; c < NPIX && !found; c++) begin
      @(negedge clk);
      if (bus.bram_we === 1'b1 && bus.bram_addr === 18'd1000) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmc_reach_1000: got %b want 1", found); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.bram_we !== 1'b0)     begin n_fail++; $display("FAIL rmc_we: got %b want 0", bus.bram_we); end
    n_checks++; if (bus.bram_addr !== 18'd0)  begin n_fail++; $display("FAIL rmc_addr: got %0d want 0", bus.bram_addr); end
    n_checks++; if (bus.bram_din !== 16'd0)   begin n_fail++; $display("FAIL rmc_din: got %h want 0", bus.bram_din); end
    n_checks++; if (bus.clear_busy !== 1'b0)  begin n_fail++; $display("FAIL rmc_busy: got %b want 0", bus.clear_busy); end
    @(negedge clk); rst = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.clear_done !== 1'b0 || bus.bram_we !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rmc_quiet: got %b want 0", saw); end
    bus.clear_start = 1'b1;
    @(negedge clk); bus.clear_start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 18'd0) begin n_fail++; $display("FAIL rmc_restart: got we=%b addr=%0d want we=1 addr=0", bus.bram_we, bus.bram_addr); end
    for (int c = 0; c < NPIX + 10 && !done; c++) begin
      @(negedge clk);
      if (bus.clear_done === 1'b1) done = 1'b1;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmc_restart_done: got %b want 1", done); end
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_out_of_range();
    test_back_to_back();
`ifdef PIXEL_ARB_CLEAR_EN
    test_full_clear();
    test_clear_backpressure();
    test_reset_mid_clear();
`else
    test_clear_ignored();
`endif
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
